data_memory_banked: RTL and testbench

Parametrised, byte-addressed RISC-V data memory built from four byte-lane banks, with a registered one-cycle read port, byte/half/word stores and sign/zero-extending loads. It adds a post-reset clear sweep, alignment and range checking, and fault reporting. It sits in the MEM stage, driven by the load/store unit. It replaces the fixed 100-byte combinational-read memory.

---
 rtl/data_mem_pkg.sv | 51 +++++
 rtl/data_memory_banked_if.sv | 35 +++
 rtl/byte_lane_ram.sv | 34 +++
 rtl/data_memory_banked.sv | 126 ++++++++++++
 tb/tb_data_memory_banked.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/data_mem_pkg.sv
//------------------------------------------------------------------------------
// Module   : data_mem_pkg
// Brief    : Shared encodings and helpers for the banked RISC-V data memory.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package data_mem_pkg;

  localparam logic [1:0] LEN_NONE = 2'b00;
  localparam logic [1:0] LEN_BYTE = 2'b01;
  localparam logic [1:0] LEN_HALF = 2'b10;
  localparam logic [1:0] LEN_WORD = 2'b11;

  localparam int FAULT_MISALIGN = 0;
  localparam int FAULT_RANGE    = 1;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_e;

  function automatic logic [1:0] access_fault(input logic [1:0] len,
                                              input logic [1:0] lane,
                                              input logic       oor);
    logic [1:0] f;
    f = '0;
    f[FAULT_RANGE] = oor;
    case (len)
      LEN_HALF: f[FAULT_MISALIGN] = lane[0];
      LEN_WORD: f[FAULT_MISALIGN] = |lane;
      default:  f[FAULT_MISALIGN] = 1'b0;
    endcase
    return f;
  endfunction

  function automatic logic [3:0] byte_enables(input logic [1:0] len,
                                              input logic [1:0] lane);
    logic [3:0] be;
    case (len)
      LEN_BYTE: be = 4'b0001 << lane;
      LEN_HALF: be = 4'b0011 << lane;
      LEN_WORD: be = 4'b1111;
      default:  be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

`default_nettype wire

// File: rtl/data_memory_banked_if.sv
//------------------------------------------------------------------------------
// Module   : data_memory_banked_if
// Brief    : Load/store bus between the LSU (master) and the data memory (slave).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface data_memory_banked_if;
  logic [1:0]  MEM_write_length;
  logic [31:0] MEM_write_address;
  logic [31:0] MEM_write_data;
  logic        MEM_read_en;
  logic [1:0]  MEM_read_length;
  logic        MEM_read_signed;
  logic [31:0] MEM_read_address;
  logic [31:0] MEM_read_data;
  logic        MEM_read_valid;
  logic [1:0]  MEM_read_fault;
  logic [1:0]  MEM_write_fault;
  logic        MEM_ready;

  modport master (
    output MEM_write_length, MEM_write_address, MEM_write_data,
    output MEM_read_en, MEM_read_length, MEM_read_signed, MEM_read_address,
    input  MEM_read_data, MEM_read_valid, MEM_read_fault, MEM_write_fault, MEM_ready
  );

  modport slave (
    input  MEM_write_length, MEM_write_address, MEM_write_data,
    input  MEM_read_en, MEM_read_length, MEM_read_signed, MEM_read_address,
    output MEM_read_data, MEM_read_valid, MEM_read_fault, MEM_write_fault, MEM_ready
  );
endinterface

`default_nettype wire

// File: rtl/byte_lane_ram.sv
//------------------------------------------------------------------------------
// Module   : byte_lane_ram
// Brief    : One 8-bit byte lane, single write port, registered read port.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module byte_lane_ram #(
  parameter  int DEPTH_WORDS = 256,
  localparam int AW          = $clog2(DEPTH_WORDS)
) (
  input  wire logic          clk,
  input  wire logic          we,
  input  wire logic [AW-1:0] waddr,
  input  wire logic [7:0]    wdata,
  input  wire logic          re,
  input  wire logic [AW-1:0] raddr,
  output logic      [7:0]    rdata
);

  logic [7:0] mem_q [DEPTH_WORDS];
  logic [7:0] rdata_q;

  // Non-blocking update gives old data when read and write hit the same word.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
    if (re) rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

`default_nettype wire

// File: rtl/data_memory_banked.sv
//------------------------------------------------------------------------------
// Module   : data_memory_banked
// Brief    : Four-lane byte-addressed data memory with clear sweep and faults.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module data_memory_banked
  import data_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256
) (
  input wire logic             SYS_clk,
  input wire logic             SYS_reset,
  data_memory_banked_if.slave  bus
);

  localparam int             AW       = $clog2(DEPTH_WORDS);
  localparam logic [AW-1:0]  LAST_IDX = AW'(DEPTH_WORDS - 1);

  state_e        state_q, state_d;
  logic [AW-1:0] clr_cnt_q, clr_cnt_d;
  logic          rd_valid_q, rd_valid_d;
  logic [1:0]    rd_fault_q, rd_fault_d;
  logic [1:0]    rd_lane_q, rd_lane_d;
  logic [1:0]    rd_len_q, rd_len_d;
  logic          rd_signed_q, rd_signed_d;
  logic [1:0]    wr_fault_q, wr_fault_d;

  logic          is_ready;
  logic [1:0]    wr_lane, rd_lane, rd_len;
  logic [1:0]    wr_fault, rd_fault;
  logic          wr_do, rd_do;
  logic [3:0]    ram_we;
  logic [AW-1:0] ram_waddr;
  logic [31:0]   ram_wdata;
  logic [7:0]    lane_rdata [4];
  logic [31:0]   rd_word, rd_shift, rd_ext;

  always_comb begin
    is_ready = (state_q == READY);
    wr_lane  = bus.MEM_write_address[1:0];
    rd_lane  = bus.MEM_read_address[1:0];
    rd_len   = (bus.MEM_read_length == LEN_NONE) ? LEN_WORD : bus.MEM_read_length;
    wr_fault = access_fault(bus.MEM_write_length, wr_lane, |bus.MEM_write_address[31:AW+2]);
    rd_fault = access_fault(rd_len, rd_lane, |bus.MEM_read_address[31:AW+2]);
    wr_do    = is_ready && (bus.MEM_write_length != LEN_NONE) && (wr_fault == 2'b00);
    rd_do    = is_ready && bus.MEM_read_en && (rd_fault == 2'b00);

    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    rd_valid_d  = is_ready && bus.MEM_read_en;
    rd_fault_d  = rd_valid_d ? rd_fault : 2'b00;
    rd_lane_d   = rd_lane;
    rd_len_d    = rd_len;
    rd_signed_d = bus.MEM_read_signed;
    wr_fault_d  = (is_ready && (bus.MEM_write_length != LEN_NONE)) ? wr_fault : 2'b00;

    if (state_q == CLEAR) begin
      // Sweep zeroes one full word per cycle; bus traffic is ignored meanwhile.
      ram_we    = 4'b1111;
      ram_waddr = clr_cnt_q;
      ram_wdata = '0;
      clr_cnt_d = clr_cnt_q + AW'(1);
      if (clr_cnt_q == LAST_IDX) state_d = READY;
    end else begin
      ram_we    = wr_do ? byte_enables(bus.MEM_write_length, wr_lane) : 4'b0000;
      ram_waddr = bus.MEM_write_address[AW+1:2];
      ram_wdata = bus.MEM_write_data << {wr_lane, 3'b000};
    end
  end

  always_ff @(posedge SYS_clk or posedge SYS_reset) begin
    if (SYS_reset) begin
      state_q     <= CLEAR;
      clr_cnt_q   <= '0;
      rd_valid_q  <= 1'b0;
      rd_fault_q  <= 2'b00;
      rd_lane_q   <= 2'b00;
      rd_len_q    <= LEN_WORD;
      rd_signed_q <= 1'b0;
      wr_fault_q  <= 2'b00;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      rd_valid_q  <= rd_valid_d;
      rd_fault_q  <= rd_fault_d;
      rd_lane_q   <= rd_lane_d;
      rd_len_q    <= rd_len_d;
      rd_signed_q <= rd_signed_d;
      wr_fault_q  <= wr_fault_d;
    end
  end

  for (genvar k = 0; k < 4; k++) begin : g_lane
    byte_lane_ram #(.DEPTH_WORDS(DEPTH_WORDS)) u_ram (
      .clk   (SYS_clk),
      .we    (ram_we[k]),
      .waddr (ram_waddr),
      .wdata (ram_wdata[8*k +: 8]),
      .re    (rd_do),
      .raddr (bus.MEM_read_address[AW+1:2]),
      .rdata (lane_rdata[k])
    );
  end

  always_comb begin
    rd_word  = {lane_rdata[3], lane_rdata[2], lane_rdata[1], lane_rdata[0]};
    rd_shift = rd_word >> {rd_lane_q, 3'b000};
    case (rd_len_q)
      LEN_BYTE: rd_ext = {{24{rd_signed_q & rd_shift[7]}}, rd_shift[7:0]};
      LEN_HALF: rd_ext = {{16{rd_signed_q & rd_shift[15]}}, rd_shift[15:0]};
      default:  rd_ext = rd_shift;
    endcase
  end

  // Faulting or idle results read as zero so stale lane data never leaks out.
  assign bus.MEM_read_data   = (rd_valid_q && (rd_fault_q == 2'b00)) ? rd_ext : 32'h0;
  assign bus.MEM_read_valid  = rd_valid_q;
  assign bus.MEM_read_fault  = rd_fault_q;
  assign bus.MEM_write_fault = wr_fault_q;
  assign bus.MEM_ready       = is_ready;

endmodule

`default_nettype wire

// File: tb/tb_data_memory_banked.sv
//------------------------------------------------------------------------------
// Module   : tb_data_memory_banked
// Brief    : Directed and randomized checks against a byte-array reference model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_data_memory_banked;
  import data_mem_pkg::*;

  localparam int DEPTH = 256;
  localparam int NBYTE = 4 * DEPTH;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [7:0] ref_mem [NBYTE];

  data_memory_banked_if bus();

  data_memory_banked #(.DEPTH_WORDS(DEPTH)) dut (
    .SYS_clk   (clk),
    .SYS_reset (rst),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.MEM_write_length  = LEN_NONE;
    bus.MEM_write_address = '0;
    bus.MEM_write_data    = '0;
    bus.MEM_read_en       = 1'b0;
    bus.MEM_read_length   = LEN_WORD;
    bus.MEM_read_signed   = 1'b0;
    bus.MEM_read_address  = '0;
  endtask

  function automatic int nbytes(input logic [1:0] len);
    return (len == LEN_BYTE) ? 1 : (len == LEN_HALF) ? 2 : 4;
  endfunction

  function automatic logic [1:0] mfault(input logic [1:0] len, input logic [31:0] a);
    logic [1:0] f;
    f = 2'b00;
    if ((a % nbytes(len)) != 0) f[0] = 1'b1;
    if (a >= NBYTE) f[1] = 1'b1;
    return f;
  endfunction

  function automatic logic [31:0] mload(input logic [1:0] len, input logic sgn, input logic [31:0] a);
    logic [63:0] v;
    int n;
    n = nbytes(len);
    v = '0;
    for (int k = 0; k < n; k++) v = v | (64'(ref_mem[a + k]) << (8 * k));
    if (sgn && v[8 * n - 1]) v = v | ~((64'd1 << (8 * n)) - 64'd1);
    return v[31:0];
  endfunction

  // One bus cycle: drive, predict from the model, clock, compare, update model.
  task automatic cycle(input logic [1:0] wl, input logic [31:0] wa, input logic [31:0] wd,
                       input logic re, input logic [1:0] rl, input logic rs,
                       input logic [31:0] ra);
    logic [1:0]  exp_rf, exp_wf, rl_n;
    logic [31:0] exp_rd;
    bus.MEM_write_length  = wl;
    bus.MEM_write_address = wa;
    bus.MEM_write_data    = wd;
    bus.MEM_read_en       = re;
    bus.MEM_read_length   = rl;
    bus.MEM_read_signed   = rs;
    bus.MEM_read_address  = ra;
    rl_n   = (rl == LEN_NONE) ? LEN_WORD : rl;
    exp_rf = re ? mfault(rl_n, ra) : 2'b00;
    exp_rd = (re && exp_rf == 2'b00) ? mload(rl_n, rs, ra) : 32'h0;
    exp_wf = (wl != LEN_NONE) ? mfault(wl, wa) : 2'b00;
    step();
    chk("rd_valid", {31'b0, bus.MEM_read_valid}, {31'b0, re});
    chk("rd_fault", {30'b0, bus.MEM_read_fault}, {30'b0, exp_rf});
    chk("rd_data", bus.MEM_read_data, exp_rd);
    chk("wr_fault", {30'b0, bus.MEM_write_fault}, {30'b0, exp_wf});
    if (wl != LEN_NONE && exp_wf == 2'b00)
      for (int k = 0; k < nbytes(wl); k++) ref_mem[wa + k] = wd[8 * k +: 8];
    idle();
  endtask

  task automatic sweep_check();
    for (int i = 1; i <= DEPTH; i++) begin
      step();
      chk("ready_sweep", {31'b0, bus.MEM_ready}, (i == DEPTH) ? 32'd1 : 32'd0);
      chk("valid_sweep", {31'b0, bus.MEM_read_valid}, 32'd0);
      chk("wfault_sweep", {30'b0, bus.MEM_write_fault}, 32'd0);
    end
    idle();
  endtask

  initial begin
    logic [1:0]  wl, rl;
    logic [31:0] wa, ra;
    idle();
    for (int i = 0; i < NBYTE; i++) ref_mem[i] = 8'h00;
    step();
    chk("reset_data", bus.MEM_read_data, 32'h0);
    chk("reset_ready", {31'b0, bus.MEM_ready}, 32'd0);
    chk("reset_rfault", {30'b0, bus.MEM_read_fault}, 32'd0);
    step();
    rst = 1'b0;

    // Traffic during the sweep must be ignored.
    bus.MEM_write_length  = LEN_WORD;
    bus.MEM_write_address = 32'h10;
    bus.MEM_write_data    = 32'hA5A5A5A5;
    bus.MEM_read_en       = 1'b1;
    bus.MEM_read_address  = 32'h10;
    sweep_check();

    cycle(LEN_NONE, 0, 0, 1'b1, LEN_WORD, 1'b0, 32'h3FC);
    chk("lw_3fc", bus.MEM_read_data, 32'h0);
    step();
    chk("valid_pulse", {31'b0, bus.MEM_read_valid}, 32'd0);
    cycle(LEN_NONE, 0, 0, 1'b1, LEN_WORD, 1'b0, 32'h10);
    chk("lw_10_clear", bus.MEM_read_data, 32'h0);

    cycle(LEN_WORD, 32'h10, 32'h800000FF, 1'b0, LEN_WORD, 1'b0, 0);
    cycle(LEN_NONE, 0, 0, 1'b1, LEN_BYTE, 1'b1, 32'h10);
    chk("lb_10", bus.MEM_read_data, 32'hFFFFFFFF);
    cycle(LEN_NONE, 0, 0, 1'b1, LEN_BYTE, 1'b0, 32'h13);
    chk("lbu_13", bus.MEM_read_data, 32'h00000080);
    cycle(LEN_NONE, 0, 0, 1'b1, LEN_HALF, 1'b1, 32'h12);
    chk("lh_12", bus.MEM_read_data, 32'hFFFF8000);
    cycle(LEN_NONE, 0, 0, 1'b1, LEN_HALF, 1'b0, 32'h10);
    chk("lhu_10", bus.MEM_read_data, 32'h000000FF);

    cycle(LEN_HALF, 32'h21, 32'h0000BEEF, 1'b0, LEN_WORD, 1'b0, 0);
    chk("sh_21_fault", {30'b0, bus.MEM_write_fault}, 32'd1);
    cycle(LEN_NONE, 0, 0, 1'b1, LEN_WORD, 1'b0, 32'h20);
    chk("lw_20_unchanged", bus.MEM_read_data, 32'h0);
    cycle(LEN_NONE, 0, 0, 1'b1, LEN_WORD, 1'b0, 32'h22);
    chk("lw_22_fault", {30'b0, bus.MEM_read_fault}, 32'd1);

    cycle(LEN_WORD, 32'h400, 32'hDEADBEEF, 1'b0, LEN_WORD, 1'b0, 0);
    chk("sw_400_fault", {30'b0, bus.MEM_write_fault}, 32'd2);
    cycle(LEN_NONE, 0, 0, 1'b1, LEN_WORD, 1'b0, 32'h0);
    chk("lw_0_noalias", bus.MEM_read_data, 32'h0);

    cycle(LEN_WORD, 32'h40, 32'h11223344, 1'b1, LEN_WORD, 1'b0, 32'h40);
    chk("rdw_old", bus.MEM_read_data, 32'h0);
    cycle(LEN_NONE, 0, 0, 1'b1, LEN_WORD, 1'b0, 32'h40);
    chk("rdw_new", bus.MEM_read_data, 32'h11223344);

    // Random mix of stores and loads, biased towards a small shared window.
    for (int i = 0; i < 400; i++) begin
      wl = 2'($urandom_range(0, 3));
      rl = 2'($urandom_range(0, 3));
      wa = ($urandom_range(0, 9) == 0) ? $urandom() : 32'($urandom_range(0, 127));
      ra = ($urandom_range(0, 9) == 0) ? $urandom() : 32'($urandom_range(0, 127));
      if ($urandom_range(0, 3) != 0) wa = wa & ~32'(nbytes(wl) - 1);
      if ($urandom_range(0, 3) != 0) ra = ra & ~32'(nbytes(rl) - 1);
      cycle(wl, wa, $urandom(), 1'($urandom_range(0, 1)), rl, 1'($urandom_range(0, 1)), ra);
    end

    // Reset with a load result on the bus: outputs fall immediately.
    cycle(LEN_WORD, 32'h44, 32'hCAFEF00D, 1'b1, LEN_WORD, 1'b0, 32'h40);
    #1 rst = 1'b1;
    #1;
    chk("rst_async_valid", {31'b0, bus.MEM_read_valid}, 32'd0);
    chk("rst_async_data", bus.MEM_read_data, 32'h0);
    chk("rst_async_ready", {31'b0, bus.MEM_ready}, 32'd0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 100; i++) step();
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_ready", {31'b0, bus.MEM_ready}, 32'd0);
    chk("rst_mid_wfault", {30'b0, bus.MEM_write_fault}, 32'd0);
    step();
    rst = 1'b0;
    sweep_check();
    for (int i = 0; i < NBYTE; i++) ref_mem[i] = 8'h00;
    for (int i = 0; i < DEPTH; i++) begin
      cycle(LEN_NONE, 0, 0, 1'b1, LEN_WORD, 1'b0, 32'(4 * i));
      chk("post_reset_zero", bus.MEM_read_data, 32'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
